// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN = 32;

    // Upper bounds for the shared write-match helper; callers zero-extend into these.
    localparam int MAX_WR = 8;
    localparam int MAX_AW = 8;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    // One-hot select of the highest-numbered enabled write port hitting a nonzero address.
    function automatic logic [MAX_WR-1:0] wr_winner(
        input logic [MAX_WR-1:0]        en,
        input logic [MAX_WR*MAX_AW-1:0] addrs,
        input logic [MAX_AW-1:0]        a
    );
        logic [MAX_WR-1:0] sel;
        sel = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (en[p] && (addrs[p*MAX_AW +: MAX_AW] == a) && (a != '0)) begin
                sel    = '0;
                sel[p] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback or flush.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NWR-1:0]          wr_en_i,
    input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
    input  logic                    iss_valid_i,
    input  logic [AW-1:0]           iss_rd_i,
    input  logic                    flush_i,
    output logic [NREGS-1:0]        busy_o
);

    logic [NREGS-1:0]          r_busy;
    logic [NREGS-1:0]          w_busyNext;
    logic [MAX_WR-1:0]         w_wrEnExt;
    logic [MAX_WR*MAX_AW-1:0]  w_wrAddrExt;

    for (genvar p = 0; p < MAX_WR; p++) begin : g_ext
        if (p < NWR) begin : g_used
            assign w_wrEnExt[p]                     = wr_en_i[p];
            assign w_wrAddrExt[p*MAX_AW +: MAX_AW]  = MAX_AW'(wr_addr_i[p]);
        end else begin : g_unused
            assign w_wrEnExt[p]                     = 1'b0;
            assign w_wrAddrExt[p*MAX_AW +: MAX_AW]  = '0;
        end
    end

    // Issue beats writeback on the same register since the issuing instruction is younger.
    always_comb begin : next_state
        logic [MAX_WR-1:0] w_sel;
        w_busyNext = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            w_sel = wr_winner(w_wrEnExt, w_wrAddrExt, MAX_AW'(i));
            if (|w_sel) begin
                w_busyNext[i] = 1'b0;
            end
            if (iss_valid_i && (iss_rd_i == AW'(i)) && (i != 0)) begin
                w_busyNext[i] = 1'b1;
            end
            if (flush_i) begin
                w_busyNext[i] = 1'b0;
            end
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign busy_o = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and operand hazard reporting; x0 reads 0.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NRD-1:0][AW-1:0]    rs_addr_i,
    output logic [NRD-1:0][XLEN-1:0]  rs_data_o,
    output logic [NRD-1:0]            rs_busy_o,
    input  logic [NWR-1:0]            wr_en_i,
    input  logic [NWR-1:0][AW-1:0]    wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data_i,
    input  logic                      iss_valid_i,
    input  logic [AW-1:0]             iss_rd_i,
    input  logic                      flush_i,
    output logic                      hazard_o
);

    logic [XLEN-1:0]           r_regs [NREGS];
    logic [NREGS-1:0]          w_regWe;
    logic [XLEN-1:0]           w_regWd [NREGS];
    logic [NREGS-1:0]          w_busy;
    logic [MAX_WR-1:0]         w_wrEnExt;
    logic [MAX_WR*MAX_AW-1:0]  w_wrAddrExt;

    for (genvar p = 0; p < MAX_WR; p++) begin : g_ext
        if (p < NWR) begin : g_used
            assign w_wrEnExt[p]                     = wr_en_i[p];
            assign w_wrAddrExt[p*MAX_AW +: MAX_AW]  = MAX_AW'(wr_addr_i[p]);
        end else begin : g_unused
            assign w_wrEnExt[p]                     = 1'b0;
            assign w_wrAddrExt[p*MAX_AW +: MAX_AW]  = '0;
        end
    end

    // Write decode: the helper never selects x0, so entry 0 is never enabled.
    always_comb begin : write_decode
        logic [MAX_WR-1:0] w_sel;
        for (int i = 0; i < NREGS; i++) begin
            w_sel      = wr_winner(w_wrEnExt, w_wrAddrExt, MAX_AW'(i));
            w_regWe[i] = |w_sel;
            w_regWd[i] = '0;
            for (int p = 0; p < NWR; p++) begin
                if (w_sel[p]) begin
                    w_regWd[i] = wr_data_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_regWe[i]) begin
                    r_regs[i] <= w_regWd[i];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .flush_i     (flush_i),
        .busy_o      (w_busy)
    );

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [MAX_WR-1:0] w_sel;
        logic [XLEN-1:0]   w_byp;
        logic              w_hit;

        always_comb begin
            w_sel = wr_winner(w_wrEnExt, w_wrAddrExt, MAX_AW'(rs_addr_i[r]));
            w_byp = '0;
            for (int p = 0; p < NWR; p++) begin
                if (w_sel[p]) begin
                    w_byp = wr_data_i[p];
                end
            end
        end

        // A same-cycle writeback resolves the hazard only when its data is forwarded.
        assign w_hit        = (BYPASS != 0) && (|w_sel);
        assign rs_data_o[r] = (rs_addr_i[r] == AW'(REG_ZERO)) ? '0 :
                              w_hit ? w_byp : r_regs[rs_addr_i[r]];
        assign rs_busy_o[r] = w_busy[rs_addr_i[r]] && !w_hit;
    end

    assign hazard_o = |rs_busy_o;

endmodule
